// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: fetches aligned instruction pairs from local store into an
// instruction-granular FIFO and presents up to two in-order instructions per cycle.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module inst_fetch_buffer #(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned LS_AW    = 15,
   parameter int unsigned RESET_PC = 0
) (
   input  logic             clock,
   input  logic             reset,
   output logic             imem_req,
   output logic [0:LS_AW-1] imem_addr,
   input  logic             imem_rvalid,
   input  logic [0:63]      imem_rdata,
   input  logic             branch_taken,
   input  logic [0:LS_AW-1] branch_target,
   output logic             inst0_valid,
   output logic [0:31]      inst0,
   output logic [0:LS_AW-1] inst0_pc,
   output logic             inst1_valid,
   output logic [0:31]      inst1,
   output logic [0:LS_AW-1] inst1_pc,
   input  logic [0:1]       issue_take,
   output logic [0:31]      perf_stall_cycles,
   output logic [0:15]      perf_flushes
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [0:31]      word_mem [DEPTH];
   logic [0:LS_AW-1] pc_mem   [DEPTH];

   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    head_q, head_d;
   logic [0:LS_AW-1] fetch_pc_q;
   logic [0:LS_AW-4] req_hi_q;
   logic             req_odd_q;
   logic             outstanding_q;
   logic             drop_q;

   logic [CW-1:0]    take_w, pop_n, push_n;
   logic             accept;
   logic [PW-1:0]    tail, tail1, head1;
   logic [0:LS_AW-1] fetch_aligned, pc0, pc1;
   logic             unused_pc_bits;

   function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int unsigned n);
      int unsigned s;
      s = 32'(p) + n;
      if (s >= DEPTH) s = s - DEPTH;
      return PW'(s);
   endfunction

   assign fetch_aligned  = {fetch_pc_q[0:LS_AW-4], 3'b000};
   assign pc0            = {req_hi_q, 3'b000};
   assign pc1            = {req_hi_q, 3'b100};
   assign unused_pc_bits = ^fetch_pc_q[LS_AW-2:LS_AW-1];

   // Over-sized takes are illegal; clamp so the FIFO can never underflow.
   assign take_w = CW'(issue_take);
   assign pop_n  = (take_w > count_q) ? count_q : take_w;
   assign accept = reset && outstanding_q && imem_rvalid && !drop_q && !branch_taken;
   assign push_n = accept ? (req_odd_q ? CW'(1) : CW'(2)) : '0;

   assign tail  = ptr_add(head_q, 32'(count_q));
   assign tail1 = ptr_add(tail, 1);
   assign head1 = ptr_add(head_q, 1);

   // Only one request in flight; a fresh pair must fit after this cycle's pop.
   assign imem_req  = reset && !outstanding_q && !branch_taken &&
                      ((count_q - pop_n) <= CW'(DEPTH - 2));
   assign imem_addr = fetch_aligned;

   always_comb begin
      count_d = count_q - pop_n + push_n;
      head_d  = ptr_add(head_q, 32'(pop_n));
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         count_q       <= '0;
         head_q        <= '0;
         fetch_pc_q    <= LS_AW'(RESET_PC);
         req_hi_q      <= '0;
         req_odd_q     <= 1'b0;
         // A response still in flight across reset must be discarded once it lands.
         outstanding_q <= outstanding_q && !imem_rvalid;
         drop_q        <= outstanding_q && !imem_rvalid;
      end else if (branch_taken) begin
         count_q    <= '0;
         head_q     <= '0;
         fetch_pc_q <= branch_target;
         if (outstanding_q && !imem_rvalid) begin
            drop_q <= 1'b1;
         end else begin
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
         end
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         if (outstanding_q && imem_rvalid) begin
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
         end
         if (imem_req) begin
            outstanding_q <= 1'b1;
            req_hi_q      <= fetch_pc_q[0:LS_AW-4];
            req_odd_q     <= fetch_pc_q[LS_AW-3];
            fetch_pc_q    <= fetch_aligned + LS_AW'(8);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         if (req_odd_q) begin
            word_mem[tail] <= imem_rdata[32:63];
            pc_mem[tail]   <= pc1;
         end else begin
            word_mem[tail]  <= imem_rdata[0:31];
            pc_mem[tail]    <= pc0;
            word_mem[tail1] <= imem_rdata[32:63];
            pc_mem[tail1]   <= pc1;
         end
      end
   end

   assign inst0_valid = (count_q != '0);
   assign inst1_valid = (count_q >= CW'(2));
   assign inst0       = inst0_valid ? word_mem[head_q] : '0;
   assign inst0_pc    = inst0_valid ? pc_mem[head_q]   : '0;
   assign inst1       = inst1_valid ? word_mem[head1]  : '0;
   assign inst1_pc    = inst1_valid ? pc_mem[head1]    : '0;

   take_le_count: assert property (@(posedge clock) disable iff (!reset)
      (take_w <= count_q));

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_q;
   logic [15:0] flush_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (count_q == '0 && stall_q != '1) stall_q <= stall_q + 32'd1;
         if (branch_taken && flush_q != '1) flush_q <= flush_q + 16'd1;
      end
   end

   assign perf_stall_cycles = stall_q;
   assign perf_flushes      = flush_q;
`else
   assign perf_stall_cycles = '0;
   assign perf_flushes      = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: queue-based reference model plus directed
// scenarios (fill, full, steady issue, redirects, address wrap, reset with request in flight).
module tb_inst_fetch_buffer;

   localparam int DEPTH = 8;

   logic        clock;
   logic        reset;
   logic        imem_req;
   logic [0:14] imem_addr;
   logic        imem_rvalid;
   logic [0:63] imem_rdata;
   logic        branch_taken;
   logic [0:14] branch_target;
   logic        inst0_valid;
   logic [0:31] inst0;
   logic [0:14] inst0_pc;
   logic        inst1_valid;
   logic [0:31] inst1;
   logic [0:14] inst1_pc;
   logic [0:1]  issue_take;
   logic [0:31] perf_stall_cycles;
   logic [0:15] perf_flushes;

   inst_fetch_buffer #(.DEPTH(DEPTH), .LS_AW(15), .RESET_PC(0)) dut (
      .clock             (clock),
      .reset             (reset),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_rvalid       (imem_rvalid),
      .imem_rdata        (imem_rdata),
      .branch_taken      (branch_taken),
      .branch_target     (branch_target),
      .inst0_valid       (inst0_valid),
      .inst0             (inst0),
      .inst0_pc          (inst0_pc),
      .inst1_valid       (inst1_valid),
      .inst1             (inst1),
      .inst1_pc          (inst1_pc),
      .issue_take        (issue_take),
      .perf_stall_cycles (perf_stall_cycles),
      .perf_flushes      (perf_flushes)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [0:14] pc;
      logic [0:31] w;
   } ent_t;

   int n_checks = 0;
   int n_err    = 0;

   // memory model
   int          mem_lat  = 1;
   bit          mem_pend = 0;
   int          mem_cnt  = 0;
   logic [0:14] mem_addr = '0;
   bit          cap_req  = 0;
   logic [0:14] cap_addr = '0;
   logic [0:14] req_log[$];
   bit          log_on   = 0;

   // reference model
   ent_t        mq[$];
   bit          m_out  = 0;
   bit          m_drop = 0;
   bit          m_odd  = 0;
   logic [0:14] m_fpc  = '0;
   logic [0:14] m_addr = '0;
   logic [31:0] m_stall = '0;
   logic [15:0] m_flush = '0;

   // issue-order tracking
   bit          trk_on   = 0;
   logic [0:14] trk_pc   = '0;
   logic [0:14] prev_pc  = '0;
   bit          saw_wrap = 0;

   function automatic logic [0:31] word_at(input logic [0:14] a);
      return 32'h5A00_0000 | 32'(a);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_outputs();
      int sz;
      sz = mq.size();
      check("inst0_valid", 64'(inst0_valid), 64'(sz >= 1));
      check("inst1_valid", 64'(inst1_valid), 64'(sz >= 2));
      check("inst0", 64'(inst0), (sz >= 1) ? 64'(mq[0].w) : 64'd0);
      check("inst0_pc", 64'(inst0_pc), (sz >= 1) ? 64'(mq[0].pc) : 64'd0);
      check("inst1", 64'(inst1), (sz >= 2) ? 64'(mq[1].w) : 64'd0);
      check("inst1_pc", 64'(inst1_pc), (sz >= 2) ? 64'(mq[1].pc) : 64'd0);
`ifdef FETCH_PERF_CNT_EN
      check("perf_stall", 64'(perf_stall_cycles), 64'(m_stall));
      check("perf_flush", 64'(perf_flushes), 64'(m_flush));
`else
      check("perf_stall", 64'(perf_stall_cycles), 64'd0);
      check("perf_flush", 64'(perf_flushes), 64'd0);
`endif
   endtask

   // One clock cycle: check state, drive inputs, check request, then advance the model.
   task automatic step(input int take_req, input bit br, input logic [0:14] tgt, input bit rst_v);
      int          t;
      bit          ereq;
      bit          rv;
      logic [0:31] w0, w1;
      logic [0:14] p;
      @(negedge clock);
      check_outputs();
      reset         = rst_v;
      branch_taken  = br;
      branch_target = tgt;
      t = (take_req > mq.size()) ? mq.size() : take_req;
      issue_take = 2'(t);
      if (mem_pend) mem_cnt--;
      if (mem_pend && mem_cnt == 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = {word_at(mem_addr), word_at(mem_addr + 15'd4)};
         mem_pend    = 0;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
      end
      if (trk_on && rst_v && !br) begin
         for (int k = 0; k < t; k++) begin
            p = (k == 0) ? inst0_pc : inst1_pc;
            check("issue_order", 64'(p), 64'(trk_pc));
            if (prev_pc == 15'd32764 && p == 15'd0) saw_wrap = 1;
            prev_pc = p;
            trk_pc  = trk_pc + 15'd4;
         end
      end
      #1;
      ereq = rst_v && !m_out && !br && ((mq.size() - t) <= DEPTH - 2);
      check("imem_req", 64'(imem_req), 64'(ereq));
      if (ereq) check("imem_addr", 64'(imem_addr), 64'(m_fpc & ~15'd7));
      cap_req  = imem_req;
      cap_addr = imem_addr;
      @(posedge clock);
      rv = imem_rvalid;
      w0 = imem_rdata[0:31];
      w1 = imem_rdata[32:63];
      if (cap_req && rst_v) begin
         mem_pend = 1;
         mem_cnt  = mem_lat;
         mem_addr = cap_addr;
         if (log_on) req_log.push_back(cap_addr);
      end
      if (!rst_v) begin
         mq.delete();
         m_fpc   = '0;
         m_drop  = m_out && !rv;
         m_out   = m_drop;
         m_stall = '0;
         m_flush = '0;
      end else begin
         if (mq.size() == 0 && m_stall != 32'hFFFF_FFFF) m_stall++;
         if (br) begin
            if (m_flush != 16'hFFFF) m_flush++;
            mq.delete();
            m_fpc = tgt;
            if (m_out && !rv) m_drop = 1;
            else begin
               m_out  = 0;
               m_drop = 0;
            end
         end else begin
            repeat (t) void'(mq.pop_front());
            if (rv && m_out) begin
               if (!m_drop) begin
                  if (!m_odd) mq.push_back({m_addr, w0});
                  mq.push_back({m_addr + 15'd4, w1});
               end
               m_out  = 0;
               m_drop = 0;
            end
            if (ereq) begin
               m_out  = 1;
               m_addr = m_fpc & ~15'd7;
               m_odd  = (m_fpc & 15'd4) != 0;
               m_fpc  = m_addr + 15'd8;
            end
         end
      end
      #1;
   endtask

   initial begin
      int k;
      reset = 1'b0; issue_take = '0; branch_taken = 1'b0; branch_target = '0;
      imem_rvalid = 1'b0; imem_rdata = '0;

      // reset
      repeat (3) step(0, 0, 15'h0, 0);
      check("rst_inst0_valid", 64'(inst0_valid), 64'd0);
      check("rst_imem_req", 64'(imem_req), 64'd0);

      // fill with no consumption: four pair requests then stop
      log_on = 1;
      repeat (12) step(0, 0, 15'h0, 1);
      log_on = 0;
      check("fill_nreq", 64'(req_log.size()), 64'd4);
      for (int i = 0; i < 4 && i < req_log.size(); i++)
         check("fill_addr", 64'(req_log[i]), 64'(i * 8));
      check("fill_pc0", 64'(inst0_pc), 64'd0);
      check("fill_pc1", 64'(inst1_pc), 64'd4);
      check("fill_inst0", 64'(inst0), 64'h5A00_0000);

      // full FIFO drained one per cycle
      repeat (12) step(1, 0, 15'h0, 1);

      // steady state, two per cycle
      trk_on = 1; trk_pc = mq[0].pc;
      repeat (30) step(2, 0, 15'h0, 1);
      trk_on = 0;

      // redirect while a request to 0x40 is in flight
      mem_lat = 3;
      step(0, 1, 15'h0040, 1);
      step(0, 0, 15'h0, 1);
      check("redir_req", 64'(cap_req), 64'd1);
      check("redir_addr40", 64'(cap_addr), 64'h40);
      step(0, 1, 15'h0104, 1);
      req_log.delete(); log_on = 1;
      k = 0;
      while (!inst0_valid && k < 20) begin step(0, 0, 15'h0, 1); k++; end
      log_on = 0;
      check("br_valid_timeout", 64'(inst0_valid), 64'd1);
      check("br_first_req", (req_log.size() > 0) ? 64'(req_log[0]) : 64'hFFFF, 64'h100);
      check("br_inst0_pc", 64'(inst0_pc), 64'h104);
      check("br_inst0", 64'(inst0), 64'h5A00_0104);
      check("br_inst1_valid", 64'(inst1_valid), 64'd0);
      k = 0;
      while (!inst1_valid && k < 20) begin step(0, 0, 15'h0, 1); k++; end
      check("br_inst1_pc", 64'(inst1_pc), 64'h108);

      // redirect coincident with a response and a two-wide take
      mem_lat = 1;
      k = 0;
      do begin step(0, 0, 15'h0, 1); k++; end while (!(cap_req && mq.size() >= 2) && k < 20);
      check("coinc_setup", 64'(cap_req), 64'd1);
      step(2, 1, 15'h0200, 1);
      check("coinc_empty", 64'(inst0_valid), 64'd0);
      step(0, 0, 15'h0, 1);
      check("coinc_req", 64'(cap_req), 64'd1);
      check("coinc_addr", 64'(cap_addr), 64'h200);
      check("coinc_still_empty", 64'(inst0_valid), 64'd0);

      // address wrap at the top of local store
      step(0, 1, 15'h7FE0, 1);
      trk_on = 1; trk_pc = 15'h7FE0; prev_pc = '0; saw_wrap = 0;
      repeat (60) step(2, 0, 15'h0, 1);
      trk_on = 0;
      check("wrap_seen", 64'(saw_wrap), 64'd1);

      // reset with a request in flight; its late response must be ignored
      mem_lat = 5;
      k = 0;
      do begin step(2, 0, 15'h0, 1); k++; end while (!cap_req && k < 10);
      check("rst_setup", 64'(cap_req), 64'd1);
      repeat (2) step(0, 0, 15'h0, 0);
      mem_lat = 1;
      req_log.delete(); log_on = 1;
      k = 0;
      while (req_log.size() == 0 && k < 20) begin step(0, 0, 15'h0, 1); k++; end
      log_on = 0;
      check("rst_first_req", (req_log.size() > 0) ? 64'(req_log[0]) : 64'hFFFF, 64'd0);
      check("rst_flushes", 64'(perf_flushes), 64'd0);
      repeat (3) step(0, 0, 15'h0, 1);
      check("rst_inst0_pc", 64'(inst0_pc), 64'd0);
      check("rst_inst1_pc", 64'(inst1_pc), 64'd4);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
